// File: rtl/kyber_pkg.sv
// Shared Kyber definitions: seed/XOF widths, coefficient-RAM addressing,
// matrix index width and the Â scheduler state encoding.
package kyber_pkg;

    localparam int KYBER_SEED_W   = 256;
    localparam int XOF_IN_W       = 272;
    localparam int RAM_ADDR_W     = 9;
    localparam int POLY_WORDS_DEF = 32;
    localparam int IDX_W          = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_ADVANCE,
        ST_DONE
    } a_sched_state_t;

    // Matrix indices enter the XOF seed as zero-extended bytes.
    function automatic logic [7:0] idx_byte(input logic [IDX_W-1:0] idx);
        return {{(8 - IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/a_sched_index_ctr.sv
// Nested (i, j) counter for walking a K x K matrix in row-major order.
// j wraps to 0 and carries into i; last flags entry (K-1, K-1).
module a_sched_index_ctr
    import kyber_pkg::*;
#(
    parameter int K = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] row_idx,
    output logic [IDX_W-1:0] col_idx,
    output logic             last
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(K - 1);

    // Row-major stepping: column first, carry into row, full wrap after the last entry.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            row_idx <= '0;
            col_idx <= '0;
        end else if (clear) begin
            row_idx <= '0;
            col_idx <= '0;
        end else if (advance) begin
            if (col_idx == IDX_MAX) begin
                col_idx <= '0;
                row_idx <= (row_idx == IDX_MAX) ? '0 : row_idx + IDX_W'(1);
            end else begin
                col_idx <= col_idx + IDX_W'(1);
            end
        end
    end

    assign last = (row_idx == IDX_MAX) && (col_idx == IDX_MAX);

endmodule

// File: rtl/a_matrix_scheduler.sv
// Sequencer that generates the full K x K public matrix Â by launching the
// polynomial generator once per entry with seed {byte1, byte0, rho}.
// Optional macro A_SCHED_TIMEOUT_EN adds a WAIT watchdog and an error pulse.
module a_matrix_scheduler
    import kyber_pkg::*;
#(
    parameter int K           = 3,
    parameter int POLY_WORDS  = POLY_WORDS_DEF,
    parameter int BASE_OFFSET = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    transpose,
    input  logic [KYBER_SEED_W-1:0] rho,
    output logic                    busy,
    output logic                    done,
`ifdef A_SCHED_TIMEOUT_EN
    output logic                    error,
`endif
    output logic [XOF_IN_W-1:0]     gen_M,
    output logic                    gen_active,
    output logic [RAM_ADDR_W-1:0]   gen_start_offset,
    input  logic                    gen_finish,
    output logic [IDX_W-1:0]        row_idx,
    output logic [IDX_W-1:0]        col_idx
);

    localparam int LAST_WORD = BASE_OFFSET + (K * K - 1) * POLY_WORDS + POLY_WORDS - 1;
    localparam logic [RAM_ADDR_W-1:0] PW_STEP  = RAM_ADDR_W'(POLY_WORDS);
    localparam logic [RAM_ADDR_W-1:0] BASE_ADR = RAM_ADDR_W'(BASE_OFFSET);

    if (K < 2 || K > 4) begin : g_rank_check
        $error("a_matrix_scheduler: K=%0d outside 2..4", K);
    end
    if (LAST_WORD > (2 ** RAM_ADDR_W) - 1) begin : g_range_check
        $error("a_matrix_scheduler: matrix ends at word %0d, beyond RAM", LAST_WORD);
    end

    a_sched_state_t          state_q, state_d;
    logic [KYBER_SEED_W-1:0] rho_q;
    logic                    transpose_q;
    logic [RAM_ADDR_W-1:0]   offset_q;
    logic                    idx_clear, idx_advance, idx_last;
    logic [7:0]              byte0, byte1;

    a_sched_index_ctr #(.K(K)) u_idx (
        .clk     (clk),
        .rst     (rst),
        .clear   (idx_clear),
        .advance (idx_advance),
        .row_idx (row_idx),
        .col_idx (col_idx),
        .last    (idx_last)
    );

`ifdef A_SCHED_TIMEOUT_EN
    // Abort in the WAIT cycle where the counter would reach 0xFFFF.
    localparam logic [15:0] WD_LAST = 16'hFFFE;
    logic [15:0] wd_q;

    // Watchdog: cleared on each launch, counts cycles spent waiting on the generator.
    always_ff @(posedge clk) begin
        if (!rst)                      wd_q <= '0;
        else if (state_q == ST_LAUNCH) wd_q <= '0;
        else if (state_q == ST_WAIT)   wd_q <= wd_q + 16'd1;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Request capture and RAM offset stepping.
    always_ff @(posedge clk) begin
        // NOTE: rho_q is reset despite its width because gen_M must read zero out of reset.
        if (!rst) begin
            rho_q       <= '0;
            transpose_q <= 1'b0;
            offset_q    <= '0;
        end else if (state_q == ST_IDLE && start) begin
            rho_q       <= rho;
            transpose_q <= transpose;
            offset_q    <= BASE_ADR;
        end else if (state_q == ST_ADVANCE) begin
            offset_q    <= offset_q + PW_STEP;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        gen_active  = 1'b0;
        done        = 1'b0;
        idx_clear   = 1'b0;
        idx_advance = 1'b0;
`ifdef A_SCHED_TIMEOUT_EN
        error       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_clear = 1'b1;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                gen_active = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (gen_finish) begin
                    state_d = ST_ADVANCE;
                end
`ifdef A_SCHED_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    error   = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_ADVANCE: begin
                idx_advance = 1'b1;
                state_d     = idx_last ? ST_DONE : ST_LAUNCH;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy             = (state_q != ST_IDLE);
    assign gen_start_offset = offset_q;
    assign byte0            = transpose_q ? idx_byte(row_idx) : idx_byte(col_idx);
    assign byte1            = transpose_q ? idx_byte(col_idx) : idx_byte(row_idx);
    assign gen_M            = {byte1, byte0, rho_q};

endmodule

// File: tb/tb_a_matrix_scheduler.sv
// Self-checking bench for a_matrix_scheduler: a K=3 and a K=4 instance driven
// by shared stimulus, checked against an arithmetic model of the entry order.
module tb_a_matrix_scheduler;

    localparam int PW   = 32;
    localparam int BASE = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, transpose, gen_finish, sel;
    logic [255:0] rho;

    logic         busy_a, done_a, act_a, busy_b, done_b, act_b;
    logic [271:0] m_a, m_b;
    logic [8:0]   off_a, off_b;
    logic [1:0]   row_a, col_a, row_b, col_b;
`ifdef A_SCHED_TIMEOUT_EN
    logic         err_a, err_b;
`endif

    wire start_a = start & ~sel;
    wire start_b = start & sel;
    wire fin_a   = gen_finish & ~sel;
    wire fin_b   = gen_finish & sel;

    a_matrix_scheduler #(.K(3), .POLY_WORDS(PW), .BASE_OFFSET(BASE)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .transpose(transpose), .rho(rho),
        .busy(busy_a), .done(done_a),
`ifdef A_SCHED_TIMEOUT_EN
        .error(err_a),
`endif
        .gen_M(m_a), .gen_active(act_a), .gen_start_offset(off_a),
        .gen_finish(fin_a), .row_idx(row_a), .col_idx(col_a)
    );

    a_matrix_scheduler #(.K(4), .POLY_WORDS(PW), .BASE_OFFSET(BASE)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .transpose(transpose), .rho(rho),
        .busy(busy_b), .done(done_b),
`ifdef A_SCHED_TIMEOUT_EN
        .error(err_b),
`endif
        .gen_M(m_b), .gen_active(act_b), .gen_start_offset(off_b),
        .gen_finish(fin_b), .row_idx(row_b), .col_idx(col_b)
    );

    wire         act_s  = sel ? act_b  : act_a;
    wire         busy_s = sel ? busy_b : busy_a;
    wire         done_s = sel ? done_b : done_a;
    wire [8:0]   off_s  = sel ? off_b  : off_a;
    wire [1:0]   row_s  = sel ? row_b  : row_a;
    wire [1:0]   col_s  = sel ? col_b  : col_a;
    wire [271:0] m_s    = sel ? m_b    : m_a;
    wire [287:0] obs    = {act_s, busy_s, done_s, off_s, row_s, col_s, m_s};

    int checks = 0, failures = 0;
    int launches = 0, dones = 0;

    always @(posedge clk) begin
        if (act_s)  launches <= launches + 1;
        if (done_s) dones    <= dones + 1;
    end

    // Reference: entry n of a k x k matrix is (i, j) = (n / k, n % k).
    function automatic logic [271:0] model_seed(input int n, input int k, input bit tr,
                                                input logic [255:0] r);
        int i = n / k;
        int j = n % k;
        logic [7:0] b0, b1;
        b0 = tr ? 8'(i) : 8'(j);
        b1 = tr ? 8'(j) : 8'(i);
        return {b1, b0, r};
    endfunction

    function automatic logic [287:0] model_vec(input bit act, input bit bsy, input bit dn,
                                               input int n, input int k, input bit tr,
                                               input logic [255:0] r);
        int i = n / k;
        int j = n % k;
        return {act, bsy, dn, 9'(BASE + n * PW), 2'(i), 2'(j), model_seed(n, k, tr, r)};
    endfunction

    function automatic logic [255:0] ramp_rho();
        logic [255:0] r;
        for (int b = 0; b < 32; b++) r[8*b +: 8] = 8'(b);
        return r;
    endfunction

    function automatic logic [255:0] rand_rho();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; transpose = 1'b0; gen_finish = 1'b0; sel = 1'b0; rho = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if (obs !== 288'd0) begin
                failures++;
                $display("FAIL reset_values sel=%0d: got %h want 0", s, obs);
            end
        end
        sel = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    // One full matrix pass with random generator latency. noise=1 injects a finish
    // pulse during the first LAUNCH and a start request during the first WAIT;
    // abort_n >= 0 pulls rst low in that entry's WAIT and ends the pass there.
    task automatic run_matrix(input bit s, input int k, input bit tr, input logic [255:0] r,
                              input bit noise, input int abort_n);
        int l0, d0, lat;
        logic [287:0] e;
        @(negedge clk);
        sel = s;
        @(negedge clk);
        checks++;
        if (obs[287:285] !== 3'b000) begin
            failures++;
            $display("FAIL idle_before_start: got %b want 000", obs[287:285]);
        end
        l0 = launches;
        d0 = dones;
        start = 1'b1; transpose = tr; rho = r;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < k * k; n++) begin
            e = model_vec(1'b1, 1'b1, 1'b0, n, k, tr, r);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL launch k=%0d n=%0d: got %h want %h", k, n, obs, e);
            end
            gen_finish = noise && (n == 0);
            lat = noise ? 3 : int'($urandom_range(1, 4));
            @(negedge clk);
            gen_finish = 1'b0;
            for (int c = 0; c < lat; c++) begin
                e = model_vec(1'b0, 1'b1, 1'b0, n, k, tr, r);
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL wait k=%0d n=%0d c=%0d: got %h want %h", k, n, c, obs, e);
                end
                if (n == abort_n) begin
                    rst = 1'b0;
                    @(negedge clk);
                    rst = 1'b1;
                    checks++;
                    if (obs !== 288'd0) begin
                        failures++;
                        $display("FAIL reset_mid_run: got %h want 0", obs);
                    end
                    repeat (3) @(negedge clk);
                    checks++;
                    if (dones !== d0 || busy_s !== 1'b0) begin
                        failures++;
                        $display("FAIL no_done_after_reset: dones %0d busy %b want %0d 0",
                                 dones, busy_s, d0);
                    end
                    return;
                end
                if (noise && n == 0 && c == 0) begin
                    start = 1'b1; transpose = ~tr; rho = ~r;
                end
                gen_finish = (c == lat - 1);
                @(negedge clk);
                start = 1'b0;
                gen_finish = 1'b0;
            end
            e = model_vec(1'b0, 1'b1, 1'b0, n, k, tr, r);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL advance k=%0d n=%0d: got %h want %h", k, n, obs, e);
            end
            @(negedge clk);
        end
        checks++;
        if (obs[287:285] !== 3'b011) begin
            failures++;
            $display("FAIL done_pulse k=%0d: act/busy/done %b want 011", k, obs[287:285]);
        end
        start = 1'b1; transpose = tr; rho = r;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (obs[287:285] !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_done k=%0d: act/busy/done %b want 000", k, obs[287:285]);
        end
        @(negedge clk);
        checks++;
        if (obs[287:285] !== 3'b000) begin
            failures++;
            $display("FAIL start_in_done_ignored k=%0d: act/busy/done %b want 000", k, obs[287:285]);
        end
        checks++;
        if (launches - l0 !== k * k || dones - d0 !== 1) begin
            failures++;
            $display("FAIL pass_counts k=%0d: launches %0d dones %0d want %0d 1",
                     k, launches - l0, dones - d0, k * k);
        end
    endtask

    task automatic test_k3_order();
        run_matrix(1'b0, 3, 1'b0, ramp_rho(), 1'b0, -1);
    endtask

    task automatic test_k3_transpose();
        run_matrix(1'b0, 3, 1'b1, ramp_rho(), 1'b0, -1);
    endtask

    task automatic test_k4_full();
        run_matrix(1'b1, 4, 1'b0, ramp_rho(), 1'b0, -1);
        run_matrix(1'b1, 4, 1'b1, rand_rho(), 1'b0, -1);
    endtask

    task automatic test_ignored_inputs();
        int l0;
        sel = 1'b0;
        @(negedge clk);
        l0 = launches;
        gen_finish = 1'b1;
        repeat (2) @(negedge clk);
        gen_finish = 1'b0;
        @(negedge clk);
        checks++;
        if (obs[287:285] !== 3'b000 || launches !== l0) begin
            failures++;
            $display("FAIL finish_in_idle: act/busy/done %b launches %0d want 000 %0d",
                     obs[287:285], launches, l0);
        end
        run_matrix(1'b0, 3, 1'b0, rand_rho(), 1'b1, -1);
        run_matrix(1'b1, 4, 1'b1, rand_rho(), 1'b1, -1);
    endtask

    task automatic test_reset_mid_run();
        logic [255:0] r = ramp_rho();
        run_matrix(1'b0, 3, 1'b0, r, 1'b0, 4);
        run_matrix(1'b0, 3, 1'b0, r, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            bit s = 1'($urandom_range(0, 1));
            run_matrix(s, s ? 4 : 3, 1'($urandom_range(0, 1)), rand_rho(),
                       1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_k3_order();
        test_k3_transpose();
        test_k4_full();
        test_ignored_inputs();
        test_reset_mid_run();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL tb_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
